// File: rtl/mont_exp_ctrl.sv
// Modular exponentiation sequencer: base^exp mod MOD with constant-time left-to-right
// square-and-multiply around one shared Montgomery REDC multiplier.
module mont_exp_ctrl #(
    parameter int unsigned      WIDTH  = 32,
    parameter logic [WIDTH-1:0] MOD    = 32'd998244353,
    parameter logic [WIDTH-1:0] NPRIME = 32'd998244351,
    parameter logic [WIDTH-1:0] R_MOD  = 32'd301989884,
    parameter logic [WIDTH-1:0] R2_MOD = 32'd932051910
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);
    localparam int unsigned IDXW = $clog2(WIDTH);

    typedef enum logic [2:0] {StIdle, StConv, StSq, StMul, StFromm, StDone} state_e;

    state_e            state;
    logic [WIDTH-1:0]  base_r, exp_r, acc, bm;
    logic [IDXW-1:0]   idx;

    logic [WIDTH-1:0]   op_a, op_b, prod, m;
    logic [2*WIDTH-1:0] t;
    logic [WIDTH:0]     u;
    logic [WIDTH-1:0]   sum_unused;

    assign in_ready = (state == StIdle);
    assign busy     = (state != StIdle);

    // Operand selection for the single shared multiplier.
    always_comb begin
        op_a = '0;
        op_b = '0;
        case (state)
            StConv:  begin op_a = base_r; op_b = R2_MOD; end
            StSq:    begin op_a = acc;    op_b = acc;    end
            StMul:   begin op_a = acc;    op_b = bm;     end
            StFromm: begin op_a = acc;    op_b = WIDTH'(1); end
            default: ;
        endcase
    end

    // REDC: (t + ((t * NPRIME) mod R) * MOD) / R, then one conditional subtract.
    // The low half of the sum is zero by construction.
    always_comb begin
        t = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
        m = t[WIDTH-1:0] * NPRIME;
        {u, sum_unused} = {1'b0, t} + ({{(WIDTH+1){1'b0}}, m} * {{(WIDTH+1){1'b0}}, MOD});
        prod = (u >= {1'b0, MOD}) ? u[WIDTH-1:0] - MOD : u[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            base_r    <= '0;
            exp_r     <= '0;
            acc       <= '0;
            bm        <= '0;
            idx       <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (in_valid) begin
                        base_r <= base;
                        exp_r  <= exp;
                        state  <= StConv;
                    end
                end
                StConv: begin
                    bm    <= prod;
                    acc   <= R_MOD;
                    idx   <= IDXW'(WIDTH - 1);
                    state <= StSq;
                end
                StSq: begin
                    acc   <= prod;
                    state <= StMul;
                end
                StMul: begin
                    // Multiply always runs; only the write-back depends on the bit.
                    if (exp_r[idx]) acc <= prod;
                    if (idx == '0) begin
                        state <= StFromm;
                    end else begin
                        idx   <= idx - 1'b1;
                        state <= StSq;
                    end
                end
                StFromm: begin
                    result    <= prod;
                    out_valid <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Bench for mont_exp_ctrl: directed vector table, backpressure and async-reset sequences,
// and a random regression against a plain pow-mod model.
module tb_mont_exp_ctrl;
    localparam longint unsigned MODL = 64'd998244353;
    localparam int LAT = 67;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] base, exp, result;

    int checks = 0;
    int errors = 0;

    mont_exp_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .base      (base),
        .exp       (exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] b;
        logic [31:0] e;
        logic [31:0] want;
    } vec_t;

    function automatic logic [31:0] ref_pow(input logic [31:0] b, input logic [31:0] e);
        longint unsigned r = 1;
        longint unsigned x = longint'(b) % MODL;
        longint unsigned ee = longint'(e);
        while (ee != 0) begin
            if (ee[0]) r = (r * x) % MODL;
            x = (x * x) % MODL;
            ee = ee >> 1;
        end
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle. Returns once out_valid is seen
    // (or the cycle budget runs out); lat counts edges including the accepting one.
    task automatic run_op(input logic [31:0] b, input logic [31:0] e, input bit hold,
                          output logic [31:0] res, output int lat,
                          output bit busy_ok, output bit ready_ok);
        check("in_ready_before_accept", 64'(in_ready), 64'd1);
        base = b;
        exp = e;
        in_valid = 1'b1;
        out_ready = !hold;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        base = $urandom;
        exp = $urandom;
        lat = 1;
        busy_ok = 1'b1;
        ready_ok = 1'b1;
        while (!out_valid && lat < 200) begin
            if (!busy) busy_ok = 1'b0;
            if (in_ready) ready_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        if (in_ready) ready_ok = 1'b0;
        res = result;
    endtask

    task automatic finish_handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_out_valid_drop"}, 64'(out_valid), 64'd0);
        check({tag, "_idle_after"}, {62'd0, in_ready, busy}, 64'b10);
    endtask

    vec_t vecs[7];
    logic [31:0] res, b, e, held;
    int lat;
    bit busy_ok, ready_ok, stable_ok, stale_ok;

    initial begin
        vecs[0] = '{32'd2,          32'd10,        32'd1024};
        vecs[1] = '{32'd3,          32'd998244352, 32'd1};
        vecs[2] = '{32'd3,          32'd998244351, 32'd332748118};
        vecs[3] = '{32'd0,          32'd0,         32'd1};
        vecs[4] = '{32'd0,          32'd5,         32'd0};
        vecs[5] = '{32'hFFFF_FFFF,  32'd1,         32'd301989883};
        vecs[6] = '{32'd998244353,  32'd7,         32'd0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        base = '0;
        exp = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].b, vecs[i].e, 1'b0, res, lat, busy_ok, ready_ok);
            check($sformatf("vec%0d_result", i), 64'(res), 64'(vecs[i].want));
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
            check($sformatf("vec%0d_busy", i), 64'(busy_ok), 64'd1);
            check($sformatf("vec%0d_in_ready_low", i), 64'(ready_ok), 64'd1);
            finish_handshake($sformatf("vec%0d", i));
        end

        // Backpressure: hold the result for 10 cycles while a new request is offered
        run_op(32'd7, 32'd2, 1'b1, res, lat, busy_ok, ready_ok);
        check("bp_result", 64'(res), 64'd49);
        check("bp_latency", 64'(lat), 64'(LAT));
        held = res;
        stable_ok = 1'b1;
        base = 32'd5;
        exp = 32'd3;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (!out_valid || result !== held || in_ready || !busy) stable_ok = 1'b0;
        end
        check("bp_hold_stable", 64'(stable_ok), 64'd1);
        finish_handshake("bp");
        run_op(32'd5, 32'd3, 1'b0, res, lat, busy_ok, ready_ok);
        check("bp_queued_result", 64'(res), 64'd125);
        check("bp_queued_latency", 64'(lat), 64'(LAT));
        finish_handshake("bp_queued");

        // Asynchronous reset in the middle of an operation
        base = 32'd9;
        exp = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        stale_ok = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) stale_ok = 1'b0;
        end
        check("arst_no_stale", 64'(stale_ok), 64'd1);
        run_op(32'd2, 32'd10, 1'b0, res, lat, busy_ok, ready_ok);
        check("arst_next_result", 64'(res), 64'd1024);
        check("arst_next_latency", 64'(lat), 64'(LAT));
        finish_handshake("arst_next");

        // Random regression against the pow-mod model
        for (int n = 0; n < 1000; n++) begin
            int d;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'd998244353;
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       e = 32'd0;
                1:       e = $urandom_range(1, 16);
                default: e = $urandom;
            endcase
            d = $urandom_range(0, 1);
            run_op(b, e, d != 0, res, lat, busy_ok, ready_ok);
            check($sformatf("rnd%0d_result b=%0d e=%0d", n, b, e), 64'(res), 64'(ref_pow(b, e)));
            check($sformatf("rnd%0d_latency", n), 64'(lat), 64'(LAT));
            check($sformatf("rnd%0d_busy_ready", n), {62'd0, busy_ok, ready_ok}, 64'b11);
            if (d != 0) begin
                @(posedge clk);
                #1;
                check($sformatf("rnd%0d_held", n), {31'd0, out_valid, result}, {31'd0, 1'b1, res});
            end
            finish_handshake($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
